// File: rtl/cmd_frame_gen.sv
// Command framer: turns a register or ALU command into a UART byte frame,
// then collects the 0/1/2-byte response with an inter-byte timeout.
module cmd_frame_gen #(
  parameter int unsigned          TO_WIDTH = 16,
  parameter logic [TO_WIDTH-1:0]  TIMEOUT  = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [3:0]  cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic [7:0]  cmd_opa,
  input  logic [7:0]  cmd_opb,
  input  logic [3:0]  cmd_fun,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_valid,
  output logic        rsp_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [1:0]          TYPE_WR = 2'b00;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TIMEOUT - 1'b1;

  state_t              state, state_next;
  logic [1:0]          type_q;
  logic [3:0]          addr_q, fun_q;
  logic [7:0]          data_q, opa_q, opb_q;
  logic [1:0]          idx;
  logic [TO_WIDTH-1:0] cnt;
  logic                ok;
  logic [7:0]          frame_byte;
  logic [1:0]          frame_last;
  logic                rsp_last;

  // Frame contents and lengths per command type; idx doubles as the
  // received-byte count while waiting for the response.
  always_comb begin
    frame_byte = 8'h00;
    frame_last = 2'd1;
    rsp_last   = 1'b0;
    case (type_q)
      2'b00: begin
        frame_last = 2'd2;
        case (idx)
          2'd0:    frame_byte = 8'hAA;
          2'd1:    frame_byte = {4'h0, addr_q};
          default: frame_byte = data_q;
        endcase
      end
      2'b01: begin
        frame_last = 2'd1;
        frame_byte = (idx == 2'd0) ? 8'hBB : {4'h0, addr_q};
      end
      2'b10: begin
        frame_last = 2'd3;
        rsp_last   = 1'b1;
        case (idx)
          2'd0:    frame_byte = 8'hCC;
          2'd1:    frame_byte = opa_q;
          2'd2:    frame_byte = opb_q;
          default: frame_byte = {4'h0, fun_q};
        endcase
      end
      default: begin
        frame_last = 2'd1;
        rsp_last   = 1'b1;
        frame_byte = (idx == 2'd0) ? 8'hDD : {4'h0, fun_q};
      end
    endcase
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    tx_valid   = 1'b0;
    tx_byte    = 8'h00;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_byte  = frame_byte;
        if (tx_ready && idx == frame_last)
          state_next = (type_q == TYPE_WR) ? DONE : WAIT_RSP;
      end
      WAIT_RSP: begin
        // A byte arriving on the timeout cycle still counts as a byte.
        if (rx_valid) begin
          if (idx[0] == rsp_last) state_next = DONE;
        end else if (cnt == TO_LAST) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign rsp_valid   = (state == DONE) && ok;
  assign rsp_timeout = (state == DONE) && !ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      type_q   <= 2'b00;
      addr_q   <= 4'h0;
      fun_q    <= 4'h0;
      data_q   <= 8'h00;
      opa_q    <= 8'h00;
      opb_q    <= 8'h00;
      idx      <= 2'd0;
      cnt      <= '0;
      ok       <= 1'b0;
      rsp_data <= 16'h0000;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            type_q   <= cmd_type;
            addr_q   <= cmd_addr;
            fun_q    <= cmd_fun;
            data_q   <= cmd_data;
            opa_q    <= cmd_opa;
            opb_q    <= cmd_opb;
            idx      <= 2'd0;
            ok       <= 1'b1;
            rsp_data <= 16'h0000;
          end
        end
        SEND: begin
          if (tx_ready) begin
            idx <= (idx == frame_last) ? 2'd0 : idx + 2'd1;
            cnt <= '0;
          end
        end
        WAIT_RSP: begin
          if (rx_valid) begin
            cnt <= '0;
            idx <= idx + 2'd1;
            if (idx[0]) rsp_data[15:8] <= rx_byte;
            else        rsp_data       <= {8'h00, rx_byte};
          end else if (cnt == TO_LAST) begin
            ok <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_frame_gen.sv
// Self-checking bench for cmd_frame_gen: directed scenarios plus random
// commands checked against a frame/response model built from the command rules.
module tb_cmd_frame_gen;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic [7:0]  cmd_opa;
  logic [7:0]  cmd_opb;
  logic [3:0]  cmd_fun;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [15:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_timeout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_attempt;

  always #5 clk = ~clk;

  cmd_frame_gen #(.TO_WIDTH(16), .TIMEOUT(16'd8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_opa(cmd_opa),
    .cmd_opb(cmd_opb), .cmd_fun(cmd_fun),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  // Outputs are sampled 1 time unit after the rising edge, inputs driven then too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_checks++;
    n_fail++;
    $error("[TB] FAIL %s: observed no progress, expected completion within bound", tag);
  endtask

  // Runs one command end to end. Response bytes arrive at wait-cycle numbers
  // a0/a1 (counted from the first waiting cycle, -1 = never).
  task automatic apply_stimulus(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] data,
                                input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun,
                                input int stall_mode, input int a0, input int a1,
                                input logic [7:0] b0, input logic [7:0] b1, input bit stray);
    logic [7:0]  frame[$];
    logic [15:0] exp_rsp;
    int          rlen, got, idle;
    bit          timed, accepted, ready, finished;

    frame.delete();
    case (t)
      2'b00: begin frame.push_back(8'hAA); frame.push_back({4'h0, addr}); frame.push_back(data); rlen = 0; end
      2'b01: begin frame.push_back(8'hBB); frame.push_back({4'h0, addr}); rlen = 1; end
      2'b10: begin frame.push_back(8'hCC); frame.push_back(opa); frame.push_back(opb);
                   frame.push_back({4'h0, fun}); rlen = 2; end
      default: begin frame.push_back(8'hDD); frame.push_back({4'h0, fun}); rlen = 2; end
    endcase

    check_output("idle_cmd_ready", cmd_ready, 1);
    cmd_type = t; cmd_addr = addr; cmd_data = data; cmd_opa = opa; cmd_opb = opb; cmd_fun = fun;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_type = 2'($urandom_range(0, 3)); cmd_addr = 4'($urandom); cmd_data = 8'($urandom);
    cmd_opa = 8'($urandom); cmd_opb = 8'($urandom); cmd_fun = 4'($urandom);
    check_output("busy_after_cmd", busy, 1);
    check_output("cmd_ready_low", cmd_ready, 0);

    tx_attempt = 0;
    foreach (frame[i]) begin
      accepted = 1'b0;
      for (int w = 0; w < 30 && !accepted; w++) begin
        case (stall_mode)
          0:       ready = 1'b1;
          1:       ready = (tx_attempt % 2 == 0);
          default: ready = ($urandom_range(0, 2) != 0) || (w > 20);
        endcase
        tx_attempt++;
        tx_ready = ready;
        if (stray && $urandom_range(0, 1) == 1) begin
          rx_valid = 1'b1;
          rx_byte  = 8'($urandom);
        end
        check_output($sformatf("tx_valid_b%0d", i), tx_valid, 1);
        check_output($sformatf("tx_byte_b%0d", i), tx_byte, frame[i]);
        tick();
        rx_valid = 1'b0;
        accepted = ready;
      end
      if (!accepted) begin
        bound_fail("tx_handshake");
        tx_ready = 1'b0;
        return;
      end
    end
    tx_ready = 1'b0;

    exp_rsp  = 16'h0000;
    got      = 0;
    idle     = 0;
    timed    = 1'b0;
    finished = (rlen == 0);
    for (int c = 0; c < 100 && !finished; c++) begin
      check_output("wait_no_pulse", {rsp_valid, rsp_timeout}, 0);
      check_output("wait_tx_valid", tx_valid, 0);
      if ((got == 0 && c == a0) || (got == 1 && c == a1)) begin
        rx_valid = 1'b1;
        rx_byte  = (got == 0) ? b0 : b1;
        if (got == 0) exp_rsp = {8'h00, b0};
        else          exp_rsp[15:8] = b1;
        got++;
        idle = 0;
      end else begin
        idle++;
      end
      tick();
      rx_valid = 1'b0;
      if (got == rlen) finished = 1'b1;
      else if (idle == TO) begin
        timed    = 1'b1;
        finished = 1'b1;
      end
    end
    if (!finished) begin
      bound_fail("rsp_wait");
      return;
    end

    check_output("done_rsp_valid", rsp_valid, !timed);
    check_output("done_rsp_timeout", rsp_timeout, timed);
    check_output("done_rsp_data", rsp_data, exp_rsp);
    tick();
    check_output("after_done_ready", cmd_ready, 1);
    check_output("after_done_pulses", {rsp_valid, rsp_timeout}, 0);
    check_output("after_done_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed simulation still running, expected end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_addr = 4'h0; cmd_data = 8'h00;
    cmd_opa = 8'h00; cmd_opb = 8'h00; cmd_fun = 4'h0; tx_ready = 1'b0;
    rx_byte = 8'h00; rx_valid = 1'b0;
    tick();
    tick();
    check_output("rst_tx_valid", tx_valid, 0);
    check_output("rst_tx_byte", tx_byte, 8'h00);
    check_output("rst_rsp_data", rsp_data, 16'h0000);
    check_output("rst_pulses", {rsp_valid, rsp_timeout}, 0);
    check_output("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    check_output("post_rst_ready", cmd_ready, 1);

    $display("[TB] write ADDR=3 DATA=5A");
    apply_stimulus(2'b00, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0, 0, -1, -1, 8'h00, 8'h00, 1'b0);

    $display("[TB] read ADDR=2 with toggling TX_READY");
    apply_stimulus(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1, 2, -1, 8'h81, 8'h00, 1'b0);

    $display("[TB] ALU-op CC,10,20,02");
    apply_stimulus(2'b10, 4'h0, 8'h00, 8'h10, 8'h20, 4'h2, 0, 1, 3, 8'h00, 8'h02, 1'b0);

    // Stray receive strobe while idle must not disturb the last response.
    rx_valid = 1'b1;
    rx_byte  = 8'hEE;
    tick();
    rx_valid = 1'b0;
    check_output("stray_rx_rsp_data", rsp_data, 16'h0200);
    check_output("stray_rx_busy", busy, 0);
    check_output("stray_rx_pulses", {rsp_valid, rsp_timeout}, 0);

    $display("[TB] ALU-nop timeouts");
    apply_stimulus(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1, 0, -1, -1, 8'h00, 8'h00, 1'b0);
    apply_stimulus(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1, 0, 5, -1, 8'h33, 8'h00, 1'b0);
    apply_stimulus(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h4, 0, 7, 15, 8'h44, 8'h55, 1'b0);

    $display("[TB] reset during 2nd byte of ALU-op frame");
    check_output("mid_rst_idle_ready", cmd_ready, 1);
    cmd_type = 2'b10; cmd_opa = 8'h77; cmd_opb = 8'h88; cmd_fun = 4'h9;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tx_ready  = 1'b1;
    check_output("mid_rst_b0", tx_byte, 8'hCC);
    tick();
    tx_ready = 1'b0;
    check_output("mid_rst_b1", tx_byte, 8'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mid_rst_tx_valid", tx_valid, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_cmd_ready", cmd_ready, 1);
    check_output("mid_rst_tx_byte", tx_byte, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check_output("mid_rst_no_pulse", {rsp_valid, rsp_timeout}, 0);
      tick();
    end

    $display("[TB] random commands");
    for (int n = 0; n < 30; n++) begin
      logic [7:0] r0, r1;
      int a0, a1;
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      a0 = $urandom_range(0, 10);
      a1 = a0 + $urandom_range(1, 10);
      apply_stimulus(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 4'($urandom), 2, a0, a1, r0, r1, 1'b1);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_frame_gen.md
CMD_FRAME_GEN -- requirements
Module: cmd_frame_gen

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 16'd50000, meaning the number of idle CLK cycles allowed between response bytes before abort.
REQ-002 The module SHALL have parameter TO_WIDTH, default 16, meaning the timeout counter width.
REQ-003 CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 CMD_VALID  in  1  command request is present.
REQ-006 CMD_READY  out  1  command is accepted when both CMD_VALID and CMD_READY are high.
REQ-007 CMD_TYPE  in  2  00 reg write, 01 reg read, 10 ALU with operands, 11 ALU without operands.
REQ-008 CMD_ADDR  in  4  register-file address.
REQ-009 CMD_DATA  in  8  write data.
REQ-010 CMD_OPA / CMD_OPB  in  8 each  ALU operands.
REQ-011 CMD_FUN  in  4  ALU function code.
REQ-012 TX_BYTE  out  8  byte offered to the UART transmitter.
REQ-013 TX_VALID  out  1  TX_BYTE is valid.
REQ-014 TX_READY  in  1  transmitter accepts the byte.
REQ-015 RX_BYTE  in  8  response byte from the UART receiver.
REQ-016 RX_VALID  in  1  single-cycle strobe for RX_BYTE; always accepted, never back-pressured.
REQ-017 RSP_DATA  out  16  assembled response.
REQ-018 RSP_VALID  out  1  one-cycle pulse marking command completion.
REQ-019 RSP_TIMEOUT  out  1  one-cycle pulse marking a response timeout.
REQ-020 BUSY  out  1  high in every state except IDLE.

Function
REQ-021 FSM states SHALL be IDLE, SEND, WAIT_RSP and DONE; CMD_READY SHALL be high only in IDLE.
REQ-022 On a command handshake, the block SHALL register all CMD_* fields, clear the byte index and enter SEND.
REQ-023 Frames SHALL be: write AA,{4'h0,ADDR},DATA; read BB,{4'h0,ADDR}; ALU-op CC,OPA,OPB,{4'h0,FUN}; ALU-nop DD,{4'h0,FUN}.
REQ-024 In SEND, TX_VALID SHALL be 1 and TX_BYTE SHALL equal the frame byte at the current index; TX_BYTE SHALL stay stable while TX_VALID=1 and TX_READY=0.
REQ-025 On each TX handshake the index SHALL increment; on the last byte's handshake the FSM SHALL go to DONE for a write, or to WAIT_RSP otherwise.
REQ-026 In the cycle the FSM enters SEND, TX_VALID SHALL be 1, so the first byte is offered one cycle after the command handshake.
REQ-027 Expected response length SHALL be 0 bytes for write, 1 for read, and 2 for either ALU type.
REQ-028 In WAIT_RSP, byte 0 SHALL load RSP_DATA[7:0] with RSP_DATA[15:8]=0, and byte 1 SHALL load RSP_DATA[15:8].
REQ-029 Receiving the last expected byte SHALL move the FSM to DONE with a success flag.
REQ-030 RX_VALID outside WAIT_RSP SHALL be ignored; RSP_DATA SHALL be unchanged.
REQ-031 The timeout counter SHALL clear on entering WAIT_RSP and on every accepted RX byte, and SHALL increment on every other WAIT_RSP cycle.
REQ-032 When the counter reaches TIMEOUT-1 with no RX_VALID, the FSM SHALL go to DONE with the timeout flag; RX_VALID in that same cycle wins and is treated as a normal byte.
REQ-033 DONE SHALL last exactly one cycle, assert RSP_VALID (success) or RSP_TIMEOUT (timeout), and then go to IDLE.
REQ-034 For a write, RSP_DATA SHALL be 16'h0000 at RSP_VALID.
REQ-035 On timeout, RSP_DATA SHALL hold whatever partial bytes were received.
REQ-036 RSP_VALID and RSP_TIMEOUT SHALL never both be high.

Reset
REQ-037 While RST=1 at a rising edge, the FSM SHALL go to IDLE and the index and counter SHALL clear.
REQ-038 While RST=1 at a rising edge, TX_BYTE=8'h00, TX_VALID=0, RSP_DATA=16'h0000, RSP_VALID=0, RSP_TIMEOUT=0 and BUSY=0.
REQ-039 CMD_READY SHALL be 1 in the cycle after RST is deasserted.
REQ-040 Reset asserted mid-frame or mid-wait SHALL abort the command with no completion pulse; TX_VALID SHALL drop at that edge.

Verification
REQ-041 Write ADDR=4'h3, DATA=8'h5A with TX_READY=1 -> bytes AA,03,5A on consecutive cycles, then RSP_VALID with RSP_DATA=0000, then CMD_READY=1.
REQ-042 Read ADDR=4'h2, with TX_READY toggling 1/0 -> AA-free frame BB,02 with bytes held stable while stalled; RX byte 8'h81 -> RSP_VALID with RSP_DATA=0081.
REQ-043 ALU-op OPA=8'h10, OPB=8'h20, FUN=4'h2 -> frame CC,10,20,02; RX bytes 00 then 02 -> RSP_DATA=0200.
REQ-044 ALU-nop FUN=4'h1 with TIMEOUT=8 and no RX -> frame DD,01, RSP_TIMEOUT exactly 8 cycles after entering WAIT_RSP, then IDLE; a repeat with one byte 8'h33 at cycle 5 -> timeout 8 cycles after that byte, RSP_DATA=0033.
REQ-045 RST pulsed during the 2nd byte of an ALU-op frame -> next cycle TX_VALID=0, BUSY=0, CMD_READY=1, no RSP pulse; a stray RX_VALID in IDLE leaves RSP_DATA unchanged.
